// File: rtl/matrix_byte_loader.sv
// Packs a row-major N x N byte stream (N = 2..5) into a 5x5-slot matrix word
// and holds it under a valid/ack handshake until the consumer takes it.
module matrix_byte_loader #(
  parameter int unsigned ELEM_W  = 8,
  parameter int unsigned DIM_MAX = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [1:0]                         matrix_size,
  input  logic [ELEM_W-1:0]                  data_in,
  input  logic                               data_valid,
  output logic                               data_ready,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0]  matrix_out,
  output logic                               matrix_valid,
  input  logic                               matrix_ack,
  output logic                               busy,
  output logic [4:0]                         elem_count
);

  localparam int unsigned MAT_W = DIM_MAX * DIM_MAX * ELEM_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       n_q, n_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [MAT_W-1:0] mat_q, mat_d;
  logic             ready_q, valid_q, busy_q;

  logic [4:0]       slot_idx;
  logic [7:0]       bit_off;
  logic             last_elem;

  // Slot of the element at the current (row, col) cursor
  assign slot_idx  = 5'(row_q) * 5'(DIM_MAX) + 5'(col_q);
  assign bit_off   = 8'(slot_idx) * 8'(ELEM_W);
  assign last_elem = (row_q == n_q - 3'd1) && (col_q == n_q - 3'd1);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    mat_d   = mat_q;

    if (abort) begin
      // Cancel wins over everything; the partial buffer is left as-is
      state_d = ST_IDLE;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            n_d     = 3'(matrix_size) + 3'd2;
            row_d   = 3'd0;
            col_d   = 3'd0;
            cnt_d   = 5'd0;
            mat_d   = '0;
          end
        end
        ST_LOAD: begin
          if (data_valid) begin
            mat_d[bit_off +: ELEM_W] = data_in;
            cnt_d = cnt_q + 5'd1;
            if (col_q == n_q - 3'd1) begin
              col_d = 3'd0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
            if (last_elem) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (matrix_ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake flags are registered from the next state so they track state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= 3'd2;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      cnt_q   <= 5'd0;
      mat_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      ready_q <= (state_d == ST_LOAD);
      valid_q <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign data_ready   = ready_q;
  assign matrix_valid = valid_q;
  assign busy         = busy_q;
  assign elem_count   = cnt_q;
  assign matrix_out   = mat_q;

endmodule

// File: tb/tb_matrix_byte_loader.sv
// Self-checking bench for matrix_byte_loader: directed scenarios plus random
// loads, compared against a byte-list reference model of the packed matrix.
module tb_matrix_byte_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [1:0]   matrix_size;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_ready;
  logic [199:0] matrix_out;
  logic         matrix_valid;
  logic         matrix_ack;
  logic         busy;
  logic [4:0]   elem_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] bytes_q[$];

  matrix_byte_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .matrix_size(matrix_size), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .matrix_out(matrix_out),
    .matrix_valid(matrix_valid), .matrix_ack(matrix_ack), .busy(busy),
    .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  // Reference: k-th accepted byte of an N-wide row-major stream lands in slot (k/N)*5 + k%N
  function automatic logic [199:0] model(input int n);
    logic [199:0] m;
    m = '0;
    for (int k = 0; k < bytes_q.size(); k++)
      m[((k / n) * 5 + (k % n)) * 8 +: 8] = bytes_q[k];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [1:0] sz);
    start = 1'b1;
    matrix_size = sz;
    tick();
    start = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 idle cycle before every byte, 2 random idles
  task automatic send_bytes(input int first, input int count, input int gap_mode,
                            output int cycles, output logic pre_valid);
    cycles = 0;
    pre_valid = 1'b0;
    for (int k = first; k < first + count; k++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        data_valid = 1'b0;
        data_in = 8'($urandom);
        tick();
        cycles++;
      end
      data_valid = 1'b1;
      data_in = bytes_q[k];
      pre_valid = matrix_valid;
      tick();
      cycles++;
    end
    data_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    matrix_ack = 1'b1;
    tick();
    matrix_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; matrix_size = 2'b00;
    data_in = 8'h00; data_valid = 1'b0; matrix_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_tests++; if (matrix_out !== 200'd0) begin n_fail++; $display("FAIL reset_matrix: got %h expected 0", matrix_out); end
    n_tests++; if (matrix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", matrix_valid); end
    n_tests++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", data_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (elem_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", elem_count); end
  endtask

  task automatic test_2x2();
    int cyc; logic pv; logic [199:0] exp;
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_load(2'b00);
    n_tests++; if (data_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL 2x2_enter_load: got ready=%b busy=%b expected 1 1", data_ready, busy); end
    send_bytes(0, 4, 0, cyc, pv);
    exp = '0;
    exp[7:0] = 8'h11; exp[15:8] = 8'h22; exp[47:40] = 8'h33; exp[55:48] = 8'h44;
    n_tests++; if (matrix_out !== exp) begin n_fail++; $display("FAIL 2x2_matrix: got %h expected %h", matrix_out, exp); end
    n_tests++; if (matrix_valid !== 1'b1 || pv !== 1'b0 || cyc + 1 != 5) begin n_fail++; $display("FAIL 2x2_latency: got valid=%b early=%b cycles=%0d expected 1 0 5", matrix_valid, pv, cyc + 1); end
    n_tests++; if (elem_count !== 5'd4) begin n_fail++; $display("FAIL 2x2_count: got %0d expected 4", elem_count); end
    pulse_ack();
  endtask

  task automatic test_5x5_gaps();
    int cyc; logic pv; logic [199:0] exp;
    bytes_q = {};
    for (int k = 1; k <= 25; k++) bytes_q.push_back(8'(k));
    start_load(2'b11);
    send_bytes(0, 25, 1, cyc, pv);
    exp = '0;
    for (int k = 0; k < 25; k++) exp[k*8 +: 8] = 8'(k + 1);
    n_tests++; if (matrix_out !== exp) begin n_fail++; $display("FAIL 5x5_matrix: got %h expected %h", matrix_out, exp); end
    n_tests++; if (matrix_valid !== 1'b1 || pv !== 1'b0) begin n_fail++; $display("FAIL 5x5_valid_timing: got valid=%b early=%b expected 1 0", matrix_valid, pv); end
    n_tests++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL 5x5_ready_in_done: got %b expected 0", data_ready); end
    n_tests++; if (elem_count !== 5'd25) begin n_fail++; $display("FAIL 5x5_count: got %0d expected 25", elem_count); end
  endtask

  // Continues from the DONE state left by test_5x5_gaps
  task automatic test_hold();
    logic [199:0] exp;
    exp = model(5);
    data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'($urandom);
      tick();
      n_tests++; if (matrix_out !== exp || matrix_valid !== 1'b1 || data_ready !== 1'b0) begin n_fail++; $display("FAIL hold_cycle%0d: got valid=%b ready=%b mat=%h expected 1 0 %h", i, matrix_valid, data_ready, matrix_out, exp); end
    end
    data_valid = 1'b0;
    pulse_ack();
    n_tests++; if (matrix_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_after_ack: got valid=%b busy=%b expected 0 0", matrix_valid, busy); end
    n_tests++; if (matrix_out !== exp) begin n_fail++; $display("FAIL hold_keep_matrix: got %h expected %h", matrix_out, exp); end
  endtask

  task automatic test_stale_clear();
    int cyc; logic pv; logic [199:0] exp;
    bytes_q = {};
    for (int k = 0; k < 25; k++) bytes_q.push_back(8'hFF);
    start_load(2'b11);
    send_bytes(0, 25, 0, cyc, pv);
    pulse_ack();
    bytes_q = {};
    for (int k = 0; k < 9; k++) bytes_q.push_back(8'($urandom));
    start_load(2'b01);
    send_bytes(0, 9, 2, cyc, pv);
    exp = model(3);
    n_tests++; if (matrix_out !== exp || matrix_valid !== 1'b1) begin n_fail++; $display("FAIL stale_3x3: got valid=%b mat=%h expected 1 %h", matrix_valid, matrix_out, exp); end
    pulse_ack();
  endtask

  task automatic test_mid_events();
    int cyc; logic pv; logic [199:0] exp;
    bytes_q = {};
    for (int k = 0; k < 7; k++) bytes_q.push_back(8'($urandom_range(1, 255)));
    start_load(2'b10);
    send_bytes(0, 7, 0, cyc, pv);
    rst_n = 1'b0;
    #1;
    n_tests++; if (matrix_valid !== 1'b0 || elem_count !== 5'd0 || busy !== 1'b0 || data_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got valid=%b count=%0d busy=%b ready=%b expected 0 0 0 0", matrix_valid, elem_count, busy, data_ready); end
    n_tests++; if (matrix_out !== 200'd0) begin n_fail++; $display("FAIL midreset_matrix: got %h expected 0", matrix_out); end
    tick();
    rst_n = 1'b1;
    tick();
    start_load(2'b10);
    send_bytes(0, 7, 2, cyc, pv);
    // A byte offered alongside abort must not be written
    abort = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
    tick();
    abort = 1'b0; data_valid = 1'b0;
    exp = model(4);
    n_tests++; if (matrix_valid !== 1'b0 || elem_count !== 5'd0 || busy !== 1'b0 || data_ready !== 1'b0) begin n_fail++; $display("FAIL abort_state: got valid=%b count=%0d busy=%b ready=%b expected 0 0 0 0", matrix_valid, elem_count, busy, data_ready); end
    n_tests++; if (matrix_out !== exp) begin n_fail++; $display("FAIL abort_partial: got %h expected %h", matrix_out, exp); end
  endtask

  task automatic test_ignored_controls();
    int cyc; logic pv; logic [199:0] exp;
    bytes_q = {8'h5A, 8'hC3, 8'h96, 8'h3C};
    start_load(2'b00);
    send_bytes(0, 1, 0, cyc, pv);
    start = 1'b1; matrix_size = 2'b11;
    send_bytes(1, 2, 0, cyc, pv);
    start = 1'b0;
    n_tests++; if (matrix_valid !== 1'b0) begin n_fail++; $display("FAIL ignored_early_valid: got %b expected 0", matrix_valid); end
    send_bytes(3, 1, 0, cyc, pv);
    exp = model(2);
    n_tests++; if (matrix_valid !== 1'b1 || elem_count !== 5'd4) begin n_fail++; $display("FAIL ignored_complete: got valid=%b count=%0d expected 1 4", matrix_valid, elem_count); end
    n_tests++; if (matrix_out !== exp) begin n_fail++; $display("FAIL ignored_matrix: got %h expected %h", matrix_out, exp); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (matrix_valid !== 1'b1 || matrix_out !== exp) begin n_fail++; $display("FAIL ignored_start_in_done: got valid=%b mat=%h expected 1 %h", matrix_valid, matrix_out, exp); end
    pulse_ack();
  endtask

  task automatic test_random_loads();
    int cyc; int n; logic pv; logic [1:0] sz; logic [199:0] exp;
    for (int t = 0; t < 12; t++) begin
      sz = 2'($urandom_range(0, 3));
      n = int'(sz) + 2;
      bytes_q = {};
      for (int k = 0; k < n * n; k++) bytes_q.push_back(8'($urandom));
      start_load(sz);
      send_bytes(0, n * n, 2, cyc, pv);
      exp = model(n);
      n_tests++; if (matrix_out !== exp || matrix_valid !== 1'b1 || pv !== 1'b0) begin n_fail++; $display("FAIL random_load%0d_n%0d: got valid=%b early=%b mat=%h expected 1 0 %h", t, n, matrix_valid, pv, matrix_out, exp); end
      n_tests++; if (elem_count !== 5'(n * n)) begin n_fail++; $display("FAIL random_count%0d: got %0d expected %0d", t, elem_count, n * n); end
      repeat ($urandom_range(0, 3)) tick();
      pulse_ack();
    end
  endtask

  initial begin
    test_reset();
    test_2x2();
    test_5x5_gaps();
    test_hold();
    test_stale_clear();
    test_mid_events();
    test_ignored_controls();
    test_random_loads();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
